spectrogram_readout_receiver: RTL and testbench

Receiving end of the spectrogram extractor's serial readout link. It samples the 2-bit serial stream together with the start-of-time (`SL_time`), start-of-channel-word (`SL_ch`) and `sending_data` qualifiers, and reassembles complete bin words. Each word is tagged with its bin index and frame number and buffered in a small FIFO behind a valid/ready interface. It sits on the host/FPGA side of the link and lets the team loop back and check the chip's readout path in simulation and on the bench.

---
 rtl/spectrogram_readout_receiver_pkg.sv | 41 ++++
 rtl/spectrogram_readout_receiver_fifo.sv | 67 ++++++
 rtl/spectrogram_readout_receiver.sv | 179 +++++++++++++++++
 tb/tb_spectrogram_readout_receiver.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spectrogram_readout_receiver_pkg.sv
// Shared types and constants for the spectrogram readout receiver.
// Holds the FSM state enum, the FIFO entry layout and width checks.
package spectrogram_readout_receiver_pkg;

    localparam int DEF_WORD_W     = 8;
    localparam int DEF_N_BINS     = 4;
    localparam int DEF_BIN_W      = 2;
    localparam int DEF_FRAME_W    = 8;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } rx_state_e;

    // Entry layout as stored in the FIFO, MSB first: {data, bin, frame}.
    typedef struct packed {
        logic [DEF_WORD_W-1:0]  data;
        logic [DEF_BIN_W-1:0]   bin;
        logic [DEF_FRAME_W-1:0] frame;
    } rx_entry_t;

    function automatic int entry_w(int word_w, int bin_w, int frame_w);
        return word_w + bin_w + frame_w;
    endfunction

    // The shifter keeps all pairs but the last, so at least two pairs.
    function automatic bit word_w_ok(int word_w);
        return (word_w >= 4) && ((word_w % 2) == 0);
    endfunction

    function automatic bit bin_w_ok(int n_bins, int bin_w);
        return (n_bins >= 1) && (bin_w >= 1) &&
               (bin_w >= $clog2(n_bins));
    endfunction

    function automatic bit depth_ok(int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/spectrogram_readout_receiver_fifo.sv
// readout_fifo: synchronous FIFO for received bin words.
// Ports: clk_i/rst_i (async high), push_i/wdata_i, pop_i,
//        rdata_o (head entry), full_o, empty_o.
// A push onto a full FIFO is taken only when a pop happens too.
module readout_fifo
    import spectrogram_readout_receiver_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    if (!depth_ok(DEPTH)) begin : g_chk_depth
        $error("readout_fifo: DEPTH must be a power of two >= 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [AW:0]      cnt_q;
    logic             pop_ok;
    logic             push_ok;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign rdata_o = mem_q[rd_q];

    assign pop_ok  = pop_i & ~empty_o;
    // When full, the slot being freed by the pop is the one written.
    assign push_ok = push_i & (~full_o | pop_ok);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_q] <= wdata_i;
                wr_q        <= wr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_q <= rd_q + AW'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + (AW + 1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW + 1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/spectrogram_readout_receiver.sv
// Receiver for the spectrogram serial readout link: rebuilds bin
// words from 2-bit pairs, tags them with bin/frame and buffers them.
// Ports: input_serial_readout_clk, reset (async high),
//        serial_in/sl_time/sl_ch/sending_data (link side),
//        m_data/m_bin/m_frame/m_valid/m_ready (stream out),
//        frame_done pulse, err_framing/err_overflow sticky flags,
//        clear_errors (synchronous flag clear).
module spectrogram_readout_receiver
    import spectrogram_readout_receiver_pkg::*;
#(
    parameter int WORD_W     = DEF_WORD_W,
    parameter int N_BINS     = DEF_N_BINS,
    parameter int BIN_W      = DEF_BIN_W,
    parameter int FRAME_W    = DEF_FRAME_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic               input_serial_readout_clk,
    input  logic               reset,
    input  logic [1:0]         serial_in,
    input  logic               sl_time,
    input  logic               sl_ch,
    input  logic               sending_data,
    output logic [WORD_W-1:0]  m_data,
    output logic [BIN_W-1:0]   m_bin,
    output logic [FRAME_W-1:0] m_frame,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               frame_done,
    output logic               err_framing,
    output logic               err_overflow,
    input  logic               clear_errors
);

    localparam int NPAIR   = WORD_W / 2;
    localparam int CNT_W   = $clog2(NPAIR) + 1;
    localparam int ENTRY_W = entry_w(WORD_W, BIN_W, FRAME_W);

    localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'(NPAIR - 1);
    localparam logic [BIN_W:0]   NBINS_C   = (BIN_W + 1)'(N_BINS);
    localparam logic [BIN_W:0]   LAST_BIN  = (BIN_W + 1)'(N_BINS - 1);

    if (!word_w_ok(WORD_W)) begin : g_chk_word
        $error("WORD_W must be even and at least 4");
    end
    if (!bin_w_ok(N_BINS, BIN_W)) begin : g_chk_bin
        $error("BIN_W too narrow for N_BINS");
    end

    rx_state_e            state_q;
    // Holds the pairs received before the final one of a word.
    logic [WORD_W-3:0]    shift_q;
    logic [CNT_W-1:0]     pair_cnt_q;
    // One spare bit so an overrun past the last bin is visible.
    logic [BIN_W:0]       bin_q;
    logic [FRAME_W-1:0]   frame_q;
    logic                 first_frame_q;
    logic                 frame_done_q;
    logic                 err_framing_q;
    logic                 err_overflow_q;

    logic                 marker;
    logic                 word_start;
    logic                 in_shift;
    logic                 restart;
    logic                 abort;
    logic                 word_done;
    logic                 bin_in_range;
    logic                 push_req;
    logic                 push_acc;
    logic                 overflow_evt;
    logic                 framing_evt;
    logic                 frame_evt;
    logic [WORD_W-1:0]    word;
    logic [ENTRY_W-1:0]   fifo_wdata;
    logic [ENTRY_W-1:0]   fifo_rdata;
    logic                 fifo_full;
    logic                 fifo_empty;

    assign marker     = sl_time | sl_ch;
    assign word_start = sending_data & marker;
    assign in_shift   = (state_q == ST_SHIFT);

    // A marker mid-word aborts the partial word and starts a new one.
    assign restart    = in_shift & word_start;
    assign abort      = in_shift & ~sending_data;
    assign word_done  = in_shift & sending_data & ~marker &
                        (pair_cnt_q == LAST_PAIR);

    assign word       = {shift_q, serial_in};
    assign bin_in_range = (bin_q < NBINS_C);
    assign push_req   = word_done & bin_in_range;

    // With a full FIFO the push lands only if the head pops this edge.
    assign push_acc     = push_req & (~fifo_full | m_ready);
    assign overflow_evt = push_req & fifo_full & ~m_ready;
    assign framing_evt  = restart | abort | (word_done & ~bin_in_range);
    assign frame_evt    = word_start & sl_time;

    assign fifo_wdata = {word, bin_q[BIN_W-1:0], frame_q};

    always_ff @(posedge input_serial_readout_clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            shift_q        <= '0;
            pair_cnt_q     <= '0;
            bin_q          <= '0;
            frame_q        <= '0;
            first_frame_q  <= 1'b1;
            frame_done_q   <= 1'b0;
            err_framing_q  <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            frame_done_q   <= push_acc & (bin_q == LAST_BIN);
            err_framing_q  <= (err_framing_q & ~clear_errors) |
                              framing_evt;
            err_overflow_q <= (err_overflow_q & ~clear_errors) |
                              overflow_evt;

            // The first frame after reset keeps frame number 0.
            if (frame_evt) begin
                bin_q         <= '0;
                first_frame_q <= 1'b0;
                if (!first_frame_q) begin
                    frame_q <= frame_q + FRAME_W'(1);
                end
            end else if (push_req) begin
                bin_q <= bin_q + (BIN_W + 1)'(1);
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (word_start) begin
                        shift_q    <= (WORD_W - 2)'(serial_in);
                        pair_cnt_q <= CNT_W'(1);
                        state_q    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (abort) begin
                        pair_cnt_q <= '0;
                        state_q    <= ST_IDLE;
                    end else if (restart) begin
                        shift_q    <= (WORD_W - 2)'(serial_in);
                        pair_cnt_q <= CNT_W'(1);
                    end else if (word_done) begin
                        pair_cnt_q <= '0;
                        state_q    <= ST_IDLE;
                    end else begin
                        shift_q    <= word[WORD_W-3:0];
                        pair_cnt_q <= pair_cnt_q + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    readout_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk_i   (input_serial_readout_clk),
        .rst_i   (reset),
        .push_i  (push_req),
        .wdata_i (fifo_wdata),
        .pop_i   (m_ready),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign m_data       = fifo_rdata[ENTRY_W-1 -: WORD_W];
    assign m_bin        = fifo_rdata[FRAME_W +: BIN_W];
    assign m_frame      = fifo_rdata[FRAME_W-1:0];
    assign m_valid      = ~fifo_empty;
    assign frame_done   = frame_done_q;
    assign err_framing  = err_framing_q;
    assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_spectrogram_readout_receiver.sv
// Directed bench for spectrogram_readout_receiver (default params).
// Each scenario task drives the link and checks its own results.
module tb_spectrogram_readout_receiver;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] serial_in = 2'b00;
    logic       sl_time = 1'b0;
    logic       sl_ch = 1'b0;
    logic       sending_data = 1'b0;
    logic       m_ready = 1'b0;
    logic       clear_errors = 1'b0;
    logic [7:0] m_data;
    logic [1:0] m_bin;
    logic [7:0] m_frame;
    logic       m_valid;
    logic       frame_done;
    logic       err_framing;
    logic       err_overflow;

    int passed = 0;
    int total = 0;
    int fd_cnt = 0;

    spectrogram_readout_receiver dut (
        .input_serial_readout_clk (clk),
        .reset                    (reset),
        .serial_in                (serial_in),
        .sl_time                  (sl_time),
        .sl_ch                    (sl_ch),
        .sending_data             (sending_data),
        .m_data                   (m_data),
        .m_bin                    (m_bin),
        .m_frame                  (m_frame),
        .m_valid                  (m_valid),
        .m_ready                  (m_ready),
        .frame_done               (frame_done),
        .err_framing              (err_framing),
        .err_overflow             (err_overflow),
        .clear_errors             (clear_errors)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_cnt++;
    end

    function automatic logic [18:0] head();
        return {m_valid, m_data, m_bin, m_frame};
    endfunction

    task automatic pair(input logic [1:0] p, input logic t,
                        input logic c, input logic s,
                        input logic clr);
        @(negedge clk);
        serial_in    = p;
        sl_time      = t;
        sl_ch        = c;
        sending_data = s;
        clear_errors = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) pair(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_word(input logic [7:0] w, input logic t);
        pair(w[7:6], t, 1'b1, 1'b1, 1'b0);
        pair(w[5:4], 1'b0, 1'b0, 1'b1, 1'b0);
        pair(w[3:2], 1'b0, 1'b0, 1'b1, 1'b0);
        pair(w[1:0], 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic pop_one();
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        serial_in    = 2'b00;
        sl_time      = 1'b0;
        sl_ch        = 1'b0;
        sending_data = 1'b0;
        clear_errors = 1'b0;
        m_ready      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (head() !== 19'h0)
            $display("FAIL reset_head: got %h want %h", head(), 19'h0);
        else passed++;
        total++;
        if ({frame_done, err_framing, err_overflow} !== 3'b000)
            $display("FAIL reset_flags: got %b want 000",
                     {frame_done, err_framing, err_overflow});
        else passed++;
    endtask

    task automatic test_single_word();
        logic [18:0] exp;
        do_reset();
        pair(2'b10, 1'b1, 1'b1, 1'b1, 1'b0);
        pair(2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
        pair(2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
        total++;
        if (m_valid !== 1'b0)
            $display("FAIL single_early: got %b want 0", m_valid);
        else passed++;
        pair(2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
        exp = {1'b1, 8'hA5, 2'd0, 8'd0};
        total++;
        if (head() !== exp)
            $display("FAIL single_word: got %h want %h", head(), exp);
        else passed++;
        idle(2);
        total++;
        if (head() !== exp)
            $display("FAIL single_hold: got %h want %h", head(), exp);
        else passed++;
        pop_one();
        total++;
        if (m_valid !== 1'b0)
            $display("FAIL single_pop: got %b want 0", m_valid);
        else passed++;
    endtask

    task automatic test_full_frame();
        logic [18:0] exp;
        int fd0;
        do_reset();
        fd0 = fd_cnt;
        send_word(8'h11, 1'b1);
        send_word(8'h22, 1'b0);
        send_word(8'h33, 1'b0);
        send_word(8'h44, 1'b0);
        total++;
        if (frame_done !== 1'b1)
            $display("FAIL frame_done_hi: got %b want 1", frame_done);
        else passed++;
        idle(1);
        total++;
        if ({frame_done, 32'(fd_cnt - fd0)} !== {1'b0, 32'd1})
            $display("FAIL frame_done_pulse: got %b/%0d want 0/1",
                     frame_done, fd_cnt - fd0);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            exp = {1'b1, 8'(8'h11 * (i + 1)), 2'(i), 8'd0};
            total++;
            if (head() !== exp)
                $display("FAIL frame0_bin%0d: got %h want %h",
                         i, head(), exp);
            else passed++;
            pop_one();
        end
        send_word(8'h66, 1'b1);
        send_word(8'h77, 1'b0);
        idle(1);
        exp = {1'b1, 8'h66, 2'd0, 8'd1};
        total++;
        if (head() !== exp)
            $display("FAIL frame1_bin0: got %h want %h", head(), exp);
        else passed++;
        pop_one();
        exp = {1'b1, 8'h77, 2'd1, 8'd1};
        total++;
        if (head() !== exp)
            $display("FAIL frame1_bin1: got %h want %h", head(), exp);
        else passed++;
        pop_one();
    endtask

    task automatic test_mid_word_marker();
        logic [18:0] exp;
        do_reset();
        pair(2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
        pair(2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
        pair(2'b11, 1'b0, 1'b1, 1'b1, 1'b0);
        total++;
        if (err_framing !== 1'b1)
            $display("FAIL mid_err: got %b want 1", err_framing);
        else passed++;
        pair(2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        pair(2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        pair(2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1);
        exp = {1'b1, 8'hC3, 2'd0, 8'd0};
        total++;
        if (head() !== exp)
            $display("FAIL mid_word: got %h want %h", head(), exp);
        else passed++;
        pop_one();
        total++;
        if (m_valid !== 1'b0)
            $display("FAIL mid_only_one: got %b want 0", m_valid);
        else passed++;
    endtask

    task automatic test_sending_drop();
        logic [18:0] exp;
        do_reset();
        pair(2'b10, 1'b1, 1'b1, 1'b1, 1'b0);
        pair(2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
        pair(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);
        total++;
        if ({err_framing, m_valid} !== 2'b10)
            $display("FAIL drop_err: got %b want 10",
                     {err_framing, m_valid});
        else passed++;
        send_word(8'h3C, 1'b0);
        idle(1);
        exp = {1'b1, 8'h3C, 2'd0, 8'd0};
        total++;
        if (head() !== exp)
            $display("FAIL drop_idle_word: got %h want %h", head(), exp);
        else passed++;
        pop_one();
        pair(2'b11, 1'b0, 1'b1, 1'b1, 1'b0);
        pair(2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        total++;
        if (err_framing !== 1'b1)
            $display("FAIL clear_vs_err: got %b want 1", err_framing);
        else passed++;
        pair(2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        total++;
        if (err_framing !== 1'b0)
            $display("FAIL clear_err: got %b want 0", err_framing);
        else passed++;
        idle(1);
    endtask

    task automatic test_overflow();
        logic [18:0] exp;
        do_reset();
        send_word(8'h01, 1'b1);
        send_word(8'h02, 1'b0);
        send_word(8'h03, 1'b0);
        send_word(8'h04, 1'b0);
        send_word(8'h05, 1'b1);
        idle(1);
        total++;
        if ({err_overflow, err_framing} !== 2'b10)
            $display("FAIL ovf_flags: got %b want 10",
                     {err_overflow, err_framing});
        else passed++;
        for (int i = 0; i < 4; i++) begin
            exp = {1'b1, 8'(i + 1), 2'(i), 8'd0};
            total++;
            if (head() !== exp)
                $display("FAIL ovf_pop%0d: got %h want %h",
                         i, head(), exp);
            else passed++;
            pop_one();
        end
        total++;
        if (m_valid !== 1'b0)
            $display("FAIL ovf_lost: got %b want 0", m_valid);
        else passed++;

        do_reset();
        send_word(8'h01, 1'b1);
        send_word(8'h02, 1'b0);
        send_word(8'h03, 1'b0);
        send_word(8'h04, 1'b0);
        pair(2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
        pair(2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        pair(2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
        exp = {1'b1, 8'h01, 2'd0, 8'd0};
        total++;
        if (head() !== exp)
            $display("FAIL fullpop_head: got %h want %h", head(), exp);
        else passed++;
        m_ready = 1'b1;
        pair(2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
        m_ready = 1'b0;
        idle(1);
        total++;
        if (err_overflow !== 1'b0)
            $display("FAIL fullpop_noerr: got %b want 0", err_overflow);
        else passed++;
        for (int i = 1; i < 5; i++) begin
            exp = {1'b1, 8'(i + 1), 2'(i < 4 ? i : 0),
                   8'(i < 4 ? 0 : 1)};
            total++;
            if (head() !== exp)
                $display("FAIL fullpop_word%0d: got %h want %h",
                         i, head(), exp);
            else passed++;
            pop_one();
        end
    endtask

    task automatic test_async_reset();
        logic [18:0] exp;
        do_reset();
        send_word(8'h5A, 1'b1);
        pair(2'b11, 1'b0, 1'b1, 1'b1, 1'b0);
        pair(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        pair(2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
        pair(2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
        total++;
        if ({m_valid, err_framing} !== 2'b11)
            $display("FAIL arst_pre: got %b want 11",
                     {m_valid, err_framing});
        else passed++;
        #2;
        reset        = 1'b1;
        serial_in    = 2'b00;
        sending_data = 1'b0;
        #1;
        total++;
        if ({head(), frame_done, err_framing, err_overflow} !== 22'h0)
            $display("FAIL arst_outputs: got %h want 0",
                     {head(), frame_done, err_framing, err_overflow});
        else passed++;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        send_word(8'h96, 1'b1);
        idle(1);
        exp = {1'b1, 8'h96, 2'd0, 8'd0};
        total++;
        if (head() !== exp)
            $display("FAIL arst_next: got %h want %h", head(), exp);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_full_frame();
        test_mid_word_marker();
        test_sending_drop();
        test_overflow();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
